// File: rtl/ex_stage_pkg.sv
// Shared CPU constants for the execute stage: widths, opcode encodings and
// the EX/MEM pipeline register layout.
package ex_stage_pkg;

    localparam int unsigned WORD_DATA_W = 32;
    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned REG_ADDR_W  = 5;

    typedef enum logic [3:0] {
        AluOpNop  = 4'd0,
        AluOpAnd  = 4'd1,
        AluOpOr   = 4'd2,
        AluOpXor  = 4'd3,
        AluOpAdds = 4'd4,
        AluOpAddu = 4'd5,
        AluOpSubs = 4'd6,
        AluOpSubu = 4'd7,
        AluOpShrl = 4'd8,
        AluOpShll = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MemOpNop = 2'd0,
        MemOpLdw = 2'd1,
        MemOpStw = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        CtrlOpNop  = 2'd0,
        CtrlOpWrcr = 2'd1,
        CtrlOpExrt = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        IsaExpNoExp     = 3'd0,
        IsaExpExtInt    = 3'd1,
        IsaExpUndefInsn = 3'd2,
        IsaExpOverflow  = 3'd3,
        IsaExpMissAlign = 3'd4,
        IsaExpTrap      = 3'd5,
        IsaExpPrvVio    = 3'd6
    } isa_exp_e;

    // EX/MEM register contents, kept as plain vectors so ports map directly.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             mem_op;
        logic [WORD_DATA_W-1:0] mem_wr_data;
        logic [1:0]             ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [2:0]             exp_code;
        logic [WORD_DATA_W-1:0] out;
    } ex_reg_t;

    // Bubble contents: invalid slot, no side effects, GPR write disabled.
    function automatic ex_reg_t ex_reg_bubble();
        ex_reg_t r;
        r          = '0;
        r.mem_op   = MemOpNop;
        r.ctrl_op  = CtrlOpNop;
        r.gpr_we_  = 1'b1;
        r.exp_code = IsaExpNoExp;
        return r;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU with signed-overflow detection for ADDS/SUBS.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [3:0]             op,
    input  logic [WORD_DATA_W-1:0] a,
    input  logic [WORD_DATA_W-1:0] b,
    output logic [WORD_DATA_W-1:0] out,
    output logic                   of
);

    localparam int unsigned MSB = WORD_DATA_W - 1;

    // Operation select; undefined codes yield zero.
    always_comb begin
        out = '0;
        case (op)
            AluOpNop:  out = a;
            AluOpAnd:  out = a & b;
            AluOpOr:   out = a | b;
            AluOpXor:  out = a ^ b;
            AluOpAdds: out = a + b;
            AluOpAddu: out = a + b;
            AluOpSubs: out = a - b;
            AluOpSubu: out = a - b;
            AluOpShrl: out = a >> b[4:0];
            AluOpShll: out = a << b[4:0];
            default:   out = '0;
        endcase
    end

    // Signed overflow: result sign disagrees with what the operand signs allow.
    always_comb begin
        of = 1'b0;
        case (op)
            AluOpAdds: of = (a[MSB] == b[MSB]) && (out[MSB] != a[MSB]);
            AluOpSubs: of = (a[MSB] != b[MSB]) && (out[MSB] != a[MSB]);
            default:   of = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU evaluation, forwarding to decode and the EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] id_pc,
    input  logic                   id_en,
    input  logic [3:0]             id_alu_op,
    input  logic [WORD_DATA_W-1:0] id_alu_in_0,
    input  logic [WORD_DATA_W-1:0] id_alu_in_1,
    input  logic                   id_br_flag,
    input  logic [1:0]             id_mem_op,
    input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
    input  logic [1:0]             id_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  id_dst_addr,
    input  logic                   id_gpr_we_,
    input  logic [2:0]             id_exp_code,
    output logic [WORD_DATA_W-1:0] fwd_data,
    output logic [WORD_ADDR_W-1:0] ex_pc,
    output logic                   ex_en,
    output logic                   ex_br_flag,
    output logic [1:0]             ex_mem_op,
    output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    output logic [1:0]             ex_ctrl_op,
    output logic [REG_ADDR_W-1:0]  ex_dst_addr,
    output logic                   ex_gpr_we_,
    output logic [2:0]             ex_exp_code,
    output logic [WORD_DATA_W-1:0] ex_out
);

    logic [WORD_DATA_W-1:0] alu_out;
    logic                   alu_of;
    logic                   take_of;
    ex_reg_t                ex_q;
    ex_reg_t                ex_d;

    ex_alu u_ex_alu (
        .op  (id_alu_op),
        .a   (id_alu_in_0),
        .b   (id_alu_in_1),
        .out (alu_out),
        .of  (alu_of)
    );

    assign fwd_data = alu_out;

    // Only a valid signed add/sub can turn into an overflow exception.
    assign take_of = id_en && alu_of &&
                     ((id_alu_op == AluOpAdds) || (id_alu_op == AluOpSubs));

    // Next-state selection: stall holds, flush bubbles, overflow kills side effects.
    always_comb begin
        ex_d = ex_q;
        if (stall) begin
            ex_d = ex_q;
        end else if (flush) begin
            ex_d = ex_reg_bubble();
        end else begin
            ex_d.pc          = id_pc;
            ex_d.en          = id_en;
            ex_d.br_flag     = id_br_flag;
            ex_d.mem_wr_data = id_mem_wr_data;
            ex_d.dst_addr    = id_dst_addr;
            ex_d.out         = alu_out;
            if (take_of) begin
                ex_d.mem_op   = MemOpNop;
                ex_d.ctrl_op  = CtrlOpNop;
                ex_d.gpr_we_  = 1'b1;
                ex_d.exp_code = IsaExpOverflow;
            end else begin
                ex_d.mem_op   = id_mem_op;
                ex_d.ctrl_op  = id_ctrl_op;
                ex_d.gpr_we_  = id_gpr_we_;
                ex_d.exp_code = id_exp_code;
            end
        end
    end

    // EX/MEM register with synchronous reset taking priority over stall/flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= ex_reg_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_pc          = ex_q.pc;
    assign ex_en          = ex_q.en;
    assign ex_br_flag     = ex_q.br_flag;
    assign ex_mem_op      = ex_q.mem_op;
    assign ex_mem_wr_data = ex_q.mem_wr_data;
    assign ex_ctrl_op     = ex_q.ctrl_op;
    assign ex_dst_addr    = ex_q.dst_addr;
    assign ex_gpr_we_     = ex_q.gpr_we_;
    assign ex_exp_code    = ex_q.exp_code;
    assign ex_out         = ex_q.out;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected EX/MEM contents,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_ex_stage;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  mem_op;
        logic [31:0] wd;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  code;
        logic [31:0] out;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [29:0] id_pc;
    logic        id_en;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0, id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_pc          (id_pc),
        .id_en          (id_en),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_br_flag     (id_br_flag),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_ctrl_op     (id_ctrl_op),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_exp_code    (id_exp_code),
        .fwd_data       (fwd_data),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    vec_t  exp_q[$];
    int    due_q[$];
    string name_q[$];
    vec_t  act;

    assign act = {ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
                  ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every entry whose capture edge has just passed.
    always @(negedge clk) begin
        vec_t  e;
        int    d;
        string n;
        while (exp_q.size() > 0 && due_q[0] <= cyc) begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            n = name_q.pop_front();
            n_vec++;
            if (d != cyc) begin
                n_bad++;
                $display("FAIL %s: checked at cycle %0d, was due at cycle %0d", n, cyc, d);
            end else if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    function automatic vec_t ev(input logic [29:0] pc, input logic en, input logic br,
                                input logic [1:0] mem_op, input logic [31:0] wd,
                                input logic [1:0] ctrl, input logic [4:0] dst,
                                input logic we_, input logic [2:0] code,
                                input logic [31:0] out);
        ev = {pc, en, br, mem_op, wd, ctrl, dst, we_, code, out};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic [29:0] pc, input logic br,
                         input logic [1:0] mem_op, input logic [31:0] wd,
                         input logic [1:0] ctrl, input logic [4:0] dst,
                         input logic we_, input logic [2:0] code);
        id_alu_op = op;  id_alu_in_0 = a;  id_alu_in_1 = b;  id_en = en;
        id_pc = pc;  id_br_flag = br;  id_mem_op = mem_op;  id_mem_wr_data = wd;
        id_ctrl_op = ctrl;  id_dst_addr = dst;  id_gpr_we_ = we_;  id_exp_code = code;
        #1;
    endtask

    task automatic check_fwd(input logic [31:0] x, input string n);
        n_vec++;
        if (fwd_data !== x) begin
            n_bad++;
            $display("FAIL %s: fwd_data got %h expected %h", n, fwd_data, x);
        end
    endtask

    // Queue the EX/MEM contents expected after the coming edge, then take it.
    task automatic step(input vec_t e, input string n);
        exp_q.push_back(e);
        due_q.push_back(cyc + 1);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    vec_t rst_v, ld_v;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = ev(30'h0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0);
        reset = 1'b1;  stall = 1'b1;  flush = 1'b1;
        drive(4'd5, 32'h1111_1111, 32'h2222_2222, 1'b1, 30'h3AB, 1'b1, 2'd2,
              32'h5555_AAAA, 2'd1, 5'd17, 1'b0, 3'd6);
        step(rst_v, "reset_0");
        step(rst_v, "reset_1");
        reset = 1'b0;  stall = 1'b0;  flush = 1'b0;

        // ADDU wraps without overflow
        drive(4'd5, 32'hFFFF_FFFF, 32'h1, 1'b1, 30'h100, 1'b0, 2'd0, 32'hDEAD_BEEF,
              2'd0, 5'd3, 1'b0, 3'd0);
        check_fwd(32'h0, "addu_fwd");
        step(ev(30'h100, 1, 0, 2'd0, 32'hDEAD_BEEF, 2'd0, 5'd3, 0, 3'd0, 32'h0), "addu_wrap");

        // ADDS overflow squashes side effects
        drive(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b1, 30'h104, 1'b1, 2'd2, 32'h1234_5678,
              2'd1, 5'd7, 1'b0, 3'd0);
        step(ev(30'h104, 1, 1, 2'd0, 32'h1234_5678, 2'd0, 5'd7, 1, 3'd3, 32'h8000_0000),
             "adds_of");
        // Same with id_en=0: copied unchanged
        drive(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b0, 30'h104, 1'b1, 2'd2, 32'h1234_5678,
              2'd1, 5'd7, 1'b0, 3'd0);
        step(ev(30'h104, 0, 1, 2'd2, 32'h1234_5678, 2'd1, 5'd7, 0, 3'd0, 32'h8000_0000),
             "adds_invalid");
        // ADDS without overflow keeps incoming exception code
        drive(4'd4, 32'h1, 32'h2, 1'b1, 30'h105, 1'b0, 2'd1, 32'h0, 2'd0, 5'd8, 1'b0, 3'd2);
        step(ev(30'h105, 1, 0, 2'd1, 32'h0, 2'd0, 5'd8, 0, 3'd2, 32'h3), "adds_no_of");

        // Shifts use only b[4:0]
        drive(4'd9, 32'h1, 32'h21, 1'b1, 30'h108, 1'b0, 2'd1, 32'h0, 2'd2, 5'd1, 1'b0, 3'd0);
        check_fwd(32'h2, "shll_fwd");
        step(ev(30'h108, 1, 0, 2'd1, 32'h0, 2'd2, 5'd1, 0, 3'd0, 32'h2), "shll");
        drive(4'd8, 32'h8000_0000, 32'd31, 1'b1, 30'h10C, 1'b0, 2'd0, 32'h0, 2'd0, 5'd2,
              1'b0, 3'd0);
        check_fwd(32'h1, "shrl_fwd");
        step(ev(30'h10C, 1, 0, 2'd0, 32'h0, 2'd0, 5'd2, 0, 3'd0, 32'h1), "shrl");

        // Logic ops, NOP pass-through, SUBU wrap
        drive(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 30'h110, 1'b0, 2'd0, 32'h0, 2'd0,
              5'd10, 1'b0, 3'd0);
        step(ev(30'h110, 1, 0, 2'd0, 32'h0, 2'd0, 5'd10, 0, 3'd0, 32'hF000_F000), "and");
        drive(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 30'h111, 1'b0, 2'd0, 32'h0, 2'd0,
              5'd11, 1'b0, 3'd0);
        step(ev(30'h111, 1, 0, 2'd0, 32'h0, 2'd0, 5'd11, 0, 3'd0, 32'hFFF0_FFF0), "or");
        drive(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 30'h112, 1'b0, 2'd0, 32'h0, 2'd0,
              5'd12, 1'b0, 3'd0);
        step(ev(30'h112, 1, 0, 2'd0, 32'h0, 2'd0, 5'd12, 0, 3'd0, 32'h0FF0_0FF0), "xor");
        drive(4'd0, 32'hABCD_0123, 32'hFFFF_FFFF, 1'b1, 30'h113, 1'b0, 2'd0, 32'h0, 2'd0,
              5'd13, 1'b0, 3'd0);
        step(ev(30'h113, 1, 0, 2'd0, 32'h0, 2'd0, 5'd13, 0, 3'd0, 32'hABCD_0123), "nop");
        drive(4'd7, 32'd5, 32'd7, 1'b1, 30'h114, 1'b0, 2'd0, 32'h0, 2'd0, 5'd14, 1'b0, 3'd0);
        step(ev(30'h114, 1, 0, 2'd0, 32'h0, 2'd0, 5'd14, 0, 3'd0, 32'hFFFF_FFFE), "subu");

        // Load, then stall while inputs change
        drive(4'd5, 32'd10, 32'd20, 1'b1, 30'h200, 1'b0, 2'd3, 32'h0000_CAFE, 2'd3, 5'd9,
              1'b0, 3'd5);
        ld_v = ev(30'h200, 1, 0, 2'd3, 32'h0000_CAFE, 2'd3, 5'd9, 0, 3'd5, 32'd30);
        step(ld_v, "load");
        stall = 1'b1;
        drive(4'd2, 32'h1, 32'h2, 1'b0, 30'h3FF, 1'b1, 2'd1, 32'h1, 2'd1, 5'd31, 1'b1, 3'd1);
        check_fwd(32'h3, "stall_fwd");
        step(ld_v, "stall_0");
        drive(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b1, 30'h201, 1'b0, 2'd2, 32'h2, 2'd0, 5'd4,
              1'b0, 3'd0);
        step(ld_v, "stall_1");
        drive(4'd7, 32'h9, 32'h3, 1'b1, 30'h202, 1'b1, 2'd1, 32'h3, 2'd2, 5'd6, 1'b0, 3'd4);
        step(ld_v, "stall_2");
        flush = 1'b1;
        step(ld_v, "stall_flush");
        stall = 1'b0;
        step(rst_v, "flush");
        flush = 1'b0;

        // SUBS overflow at the negative boundary, SUBS without overflow, undefined op
        drive(4'd6, 32'h8000_0000, 32'h1, 1'b1, 30'h300, 1'b0, 2'd1, 32'h77, 2'd2, 5'd4,
              1'b0, 3'd0);
        step(ev(30'h300, 1, 0, 2'd0, 32'h77, 2'd0, 5'd4, 1, 3'd3, 32'h7FFF_FFFF), "subs_of");
        drive(4'd6, 32'h8000_0000, 32'h8000_0000, 1'b1, 30'h301, 1'b0, 2'd1, 32'h78, 2'd2,
              5'd4, 1'b0, 3'd0);
        step(ev(30'h301, 1, 0, 2'd1, 32'h78, 2'd2, 5'd4, 0, 3'd0, 32'h0), "subs_no_of");
        drive(4'd12, 32'd5, 32'd6, 1'b1, 30'h304, 1'b0, 2'd2, 32'h99, 2'd1, 5'd5, 1'b0, 3'd0);
        check_fwd(32'h0, "op12_fwd");
        step(ev(30'h304, 1, 0, 2'd2, 32'h99, 2'd1, 5'd5, 0, 3'd0, 32'h0), "op12");

        // Reset asserted during a stall clears the register
        stall = 1'b1;
        reset = 1'b1;
        step(rst_v, "reset_in_stall");
        reset = 1'b0;
        stall = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never checked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
